reorder_buffer: RTL
===================

# reorder_buffer

Circular in-order reorder buffer between decode and the reservation stations. It allocates one tag per decoded instruction and answers decode's operand lookups as 65-bit `{ready, value}` words. It captures execute/memory writeback results and retires completed entries in program order to the register file. Tags are 1..ROBsize; tag 0 is reserved for "no in-flight producer, read the register file".

## Interface
- `ROBsize`, default 8: number of entries, ≥2.
- `ROBsizeLog`, default `$clog2(ROBsize+1)`: tag width, so tag ROBsize is representable.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `allocEn_i`  in  1  decode requests a new entry this cycle.
- `allocDestReg_i`  in  5  architectural destination register of the new entry.
- `allocTag_o`  out  ROBsizeLog  tag the next allocation receives (tail+1).
- `full_o`  out  1  all entries busy; allocation refused.
- `count_o`  out  ROBsizeLog  number of busy entries.
- `srcTag1_i`, `srcTag2_i`  in  ROBsizeLog  operand producer tags to look up.
- `srcVal1_o`, `srcVal2_o`  out  65  bit 64 = result ready, [63:0] = result.
- `wbEn_i`  in  1  writeback valid.
- `wbTag_i`  in  ROBsizeLog  writeback tag.
- `wbVal_i`  in  64  writeback result.
- `commitStall_i`  in  1  register file cannot accept a commit this cycle.
- `commitEn_o`  out  1  head entry retires at this clock edge.
- `commitTag_o`  out  ROBsizeLog  tag of the retiring entry.
- `commitReg_o`  out  5  destination register of the retiring entry.
- `commitVal_o`  out  64  value of the retiring entry.
- `flush_i`  in  1  synchronous clear of all entries.

## Operation
- **Storage:** per entry `busy`, `ready`, `destReg[4:0]`, `value[63:0]`. The entry at index i has tag i+1. Pointers `head` and `tail` run 0..ROBsize-1 and wrap to 0 after ROBsize-1. A separate `count` register keeps full and empty unambiguous.
- **Allocate:** when `allocEn_i & ~full_o`, set entry[tail] to busy=1, ready=0, destReg=`allocDestReg_i`, then tail+1. `allocEn_i` while full is ignored, with no state change.
- **Writeback:** when `wbEn_i` targets a busy entry, set ready=1 and value=`wbVal_i`.
  - A writeback to a non-busy entry or to tag 0 is ignored.
  - A repeat writeback to an already-ready entry overwrites its value.
- **Lookup:** combinational.
  - Tag 0 or a non-busy entry returns 65'h0.
  - A busy entry returns `{ready, value}`.
  - If `wbEn_i` is high in the same cycle with a matching tag on a busy entry, the lookup returns `{1'b1, wbVal_i}` (forwarding).
- **Commit:** `commitEn_o = busy[head] & ready[head] & ~commitStall_i & ~flush_i`. On an edge with `commitEn_o` high, clear busy[head] and advance head by 1. At most one commit per cycle.
- **Count:** +1 on allocate only, −1 on commit only, unchanged when both happen in the same cycle. `full_o = (count == ROBsize)`.
- **Full with commit:** `full_o` comes from the registered count. An allocate in a cycle where a full buffer also commits is still refused.
- **Flush:** highest priority. On the edge it clears every busy and ready bit, sets head=tail=count=0, and discards that cycle's alloc, writeback and commit.

## Timing
- Reset values (asynchronous, while `reset_n_i`=0): all busy/ready bits 0, head=tail=count=0.
  - Resulting outputs: `allocTag_o`=1, `full_o`=0, `count_o`=0, `commitEn_o`=0, `srcVal*_o`=0, `commitTag_o`=1.
  - `commitReg_o` and `commitVal_o` = 0.
- Reset mid-operation drops every in-flight entry immediately. Release is synchronous to the next `clk_i` edge.
- `allocTag_o`, `full_o`, `count_o` and all commit outputs are functions of registered state only.
- Lookups are combinational from the tag inputs plus the writeback bypass.
- Latency: allocate at edge N → entry visible to lookups (ready=0) in cycle N+1.
- Writeback at edge N → same-cycle bypass to lookups. Commit can fire no earlier than cycle N+1.
- Simultaneous writeback to the head and commit in one cycle: no commit that cycle. The commit fires the next cycle.

## Test plan
- **Reset and first allocate:** reset, then allocate destReg 3 → `allocTag_o` 1→2, `count_o`=1, lookup tag 1 = 65'h0.
- **In-order retire:** fill 8 entries, then `allocEn_i` again → `full_o`=1, ninth alloc ignored.
  - Writeback tag 2 = 0xB → no commit.
  - Writeback tag 1 = 0xA → commits tag 1 (0xA), then tag 2 (0xB) on consecutive cycles.
- **Bypass:** lookup tag 5 while `wbEn_i` writes tag 5 = 0x55 in the same cycle → `srcVal1_o` = 65'h1_0000_0000_0000_0055.
  - Next cycle, without writeback → same value from storage.
- **Wrap-around:** allocate, complete and commit 12 instructions → `allocTag_o` sequence 1..8,1..4, commits in order, `count_o` returns to 0.
- **Stall and simultaneous events:** with `commitStall_i`=1, the ready head is held (`commitEn_o`=0).
  - Release the stall while allocating in the same cycle → commit and alloc both occur, `count_o` unchanged.
- **Flush and async reset:** with 5 entries busy (2 ready), pulse `flush_i` → `count_o`=0, `commitEn_o`=0 during the flush, `allocTag_o`=1.
  - Repeat with `reset_n_i` asserted mid-cycle → outputs clear before the next edge.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags to decoded instructions, captures
// writebacks, answers operand lookups with {ready,value} and retires in program order.
module reorder_buffer #(
    parameter int ROBsize    = 8,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  allocEn_i,
    input  logic [4:0]            allocDestReg_i,
    output logic [ROBsizeLog-1:0] allocTag_o,
    output logic                  full_o,
    output logic [ROBsizeLog-1:0] count_o,
    input  logic [ROBsizeLog-1:0] srcTag1_i,
    input  logic [ROBsizeLog-1:0] srcTag2_i,
    output logic [64:0]           srcVal1_o,
    output logic [64:0]           srcVal2_o,
    input  logic                  wbEn_i,
    input  logic [ROBsizeLog-1:0] wbTag_i,
    input  logic [63:0]           wbVal_i,
    input  logic                  commitStall_i,
    output logic                  commitEn_o,
    output logic [ROBsizeLog-1:0] commitTag_o,
    output logic [4:0]            commitReg_o,
    output logic [63:0]           commitVal_o,
    input  logic                  flush_i
);
    localparam int PW = (ROBsize > 1) ? $clog2(ROBsize) : 1;
    typedef logic [PW-1:0]         ptr_t;
    typedef logic [ROBsizeLog-1:0] tag_t;

    logic [ROBsize-1:0] r_busy;
    logic [ROBsize-1:0] r_ready;
    logic [4:0]         r_dest [ROBsize];
    logic [63:0]        r_val  [ROBsize];
    ptr_t               r_head;
    ptr_t               r_tail;
    tag_t               r_count;

    logic  w_full;
    logic  w_alloc;
    logic  w_commit;
    logic  w_wbHit;
    ptr_t  w_wbIdx;
    tag_t  w_srcTag [2];
    logic [64:0] w_srcVal [2];

    // Tags outside 1..ROBsize never name an entry.
    function automatic logic tag_ok(input tag_t t);
        return (t != '0) && (int'(t) <= ROBsize);
    endfunction

    function automatic ptr_t tag2idx(input tag_t t);
        return PW'(t - tag_t'(1));
    endfunction

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PW'(ROBsize - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full   = (r_count == tag_t'(ROBsize));
    assign w_alloc  = allocEn_i & ~w_full;
    assign w_commit = r_busy[r_head] & r_ready[r_head] & ~commitStall_i & ~flush_i;
    assign w_wbIdx  = tag2idx(wbTag_i);
    assign w_wbHit  = wbEn_i & tag_ok(wbTag_i) & r_busy[w_wbIdx];

    assign w_srcTag[0] = srcTag1_i;
    assign w_srcTag[1] = srcTag2_i;

    // Same-cycle writeback is forwarded so a consumer never misses a result in flight.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_srcVal[s] = '0;
            if (tag_ok(w_srcTag[s]) && r_busy[tag2idx(w_srcTag[s])]) begin
                if (wbEn_i && (wbTag_i == w_srcTag[s]))
                    w_srcVal[s] = {1'b1, wbVal_i};
                else
                    w_srcVal[s] = {r_ready[tag2idx(w_srcTag[s])], r_val[tag2idx(w_srcTag[s])]};
            end
        end
    end

    assign srcVal1_o = w_srcVal[0];
    assign srcVal2_o = w_srcVal[1];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_tail          <= ptr_inc(r_tail);
            end
            if (w_wbHit)
                r_ready[w_wbIdx] <= 1'b1;
            if (w_commit) begin
                r_busy[r_head] <= 1'b0;
                r_head         <= ptr_inc(r_head);
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + tag_t'(1);
                2'b01:   r_count <= r_count - tag_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: every read of it is qualified by busy.
    always_ff @(posedge clk_i) begin
        if (w_alloc) begin
            r_dest[r_tail] <= allocDestReg_i;
            r_val[r_tail]  <= '0;
        end
        if (w_wbHit)
            r_val[w_wbIdx] <= wbVal_i;
    end

    assign allocTag_o  = tag_t'(r_tail) + tag_t'(1);
    assign commitTag_o = tag_t'(r_head) + tag_t'(1);
    assign full_o      = w_full;
    assign count_o     = r_count;
    assign commitEn_o  = w_commit;
    assign commitReg_o = r_busy[r_head] ? r_dest[r_head] : 5'd0;
    assign commitVal_o = r_busy[r_head] ? r_val[r_head] : 64'd0;

endmodule
